// File: rtl/poets_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : poets_stream_arbiter
// Description : Packet-locked round-robin merge of NUM_IN Avalon-ST requesters
//               onto one output stream; orphan beats are discarded while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module poets_stream_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_startofpacket,
    input  logic [NUM_IN-1:0]         in_endofpacket,
    input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
    output logic [NUM_IN-1:0]         in_ready,
    output logic                      stream_out_valid,
    output logic [DATA_W-1:0]         stream_out_data,
    output logic                      stream_out_startofpacket,
    output logic                      stream_out_endofpacket,
    output logic [EMPTY_W-1:0]        stream_out_empty,
    input  logic                      stream_out_ready,
    output logic [2:0]                grant,
    output logic                      busy,
    output logic [7:0]                drop_count,
    output logic [15:0]               pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] C_LAST_RST = 3'(NUM_IN - 1);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_grant;
    logic [2:0]         r_last_grant;
    logic [2:0]         w_sel;
    logic               w_found;
    logic [NUM_IN-1:0]  w_eligible;
    logic [NUM_IN-1:0]  w_orphan;
    logic [3:0]         w_orphan_cnt;
    logic [8:0]         w_drop_sum;
    logic [7:0]         w_drop_sat;
    logic [7:0]         r_drop_count;
    logic [15:0]        r_pkt_count;
    logic               w_own_valid;
    logic               w_own_sop;
    logic               w_own_eop;
    logic [DATA_W-1:0]  w_own_data;
    logic [EMPTY_W-1:0] w_own_empty;
    logic               w_load_grant;
    logic               w_pkt_done;

    // Offset k (1..NUM_IN) past base, wrapped into 0..NUM_IN-1.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_IN) begin
            s = s - NUM_IN;
        end
        return 3'(s);
    endfunction

    // Assertion is immediate; release is held off by two clock edges.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign w_eligible = in_valid & in_startofpacket;
    assign w_orphan   = in_valid & ~in_startofpacket;

    // Descending offsets so the nearest eligible requester is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        for (int k = NUM_IN; k >= 1; k--) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_eligible[i] && (rr_index(r_last_grant, k) == 3'(i))) begin
                    w_found = 1'b1;
                    w_sel   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        w_own_sop   = 1'b0;
        w_own_eop   = 1'b0;
        w_own_data  = '0;
        w_own_empty = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_grant == 3'(i)) begin
                w_own_valid = in_valid[i];
                w_own_sop   = in_startofpacket[i];
                w_own_eop   = in_endofpacket[i];
                w_own_data  = in_data[i*DATA_W +: DATA_W];
                w_own_empty = in_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
    end

    always_comb begin
        w_orphan_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_orphan_cnt = w_orphan_cnt + 4'(w_orphan[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + 9'(w_orphan_cnt);
    assign w_drop_sat = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_load_grant     = 1'b0;
        w_pkt_done       = 1'b0;
        in_ready         = '0;
        stream_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rst_n) begin
                    in_ready = w_orphan;
                end
                if (w_found) begin
                    w_state_nxt  = ST_LOCKED;
                    w_load_grant = 1'b1;
                end
            end
            ST_LOCKED: begin
                stream_out_valid = w_own_valid;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (r_grant == 3'(i)) begin
                        in_ready[i] = stream_out_ready;
                    end
                end
                if (w_own_valid && stream_out_ready && w_own_eop) begin
                    w_state_nxt = ST_IDLE;
                    w_pkt_done  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_grant      <= 3'd0;
            r_last_grant <= C_LAST_RST;
            r_drop_count <= 8'd0;
            r_pkt_count  <= 16'd0;
        end else begin
            if (w_load_grant) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
            end
            if (r_state == ST_IDLE) begin
                r_drop_count <= w_drop_sat;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign stream_out_data          = w_own_data;
    assign stream_out_startofpacket = w_own_sop;
    assign stream_out_endofpacket   = w_own_eop;
    assign stream_out_empty         = w_own_empty;
    assign grant                    = r_grant;
    assign busy                     = (r_state == ST_LOCKED);
    assign drop_count               = r_drop_count;
    assign pkt_count                = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_poets_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_poets_stream_arbiter
// Description : Randomised and directed stimulus with a queue scoreboard for
//               poets_stream_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poets_stream_arbiter;

    localparam int NUM_IN  = 4;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] e;
    } beat_t;

    logic                      clk_clk = 1'b0;
    logic                      reset_reset_n;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_startofpacket;
    logic [NUM_IN-1:0]         in_endofpacket;
    logic [NUM_IN*EMPTY_W-1:0] in_empty;
    logic [NUM_IN-1:0]         in_ready;
    logic                      stream_out_valid;
    logic [DATA_W-1:0]         stream_out_data;
    logic                      stream_out_startofpacket;
    logic                      stream_out_endofpacket;
    logic [EMPTY_W-1:0]        stream_out_empty;
    logic                      stream_out_ready;
    logic [2:0]                grant;
    logic                      busy;
    logic [7:0]                drop_count;
    logic [15:0]               pkt_count;

    poets_stream_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
        .clk_clk                  (clk_clk),
        .reset_reset_n            (reset_reset_n),
        .in_valid                 (in_valid),
        .in_data                  (in_data),
        .in_startofpacket         (in_startofpacket),
        .in_endofpacket           (in_endofpacket),
        .in_empty                 (in_empty),
        .in_ready                 (in_ready),
        .stream_out_valid         (stream_out_valid),
        .stream_out_data          (stream_out_data),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_empty         (stream_out_empty),
        .stream_out_ready         (stream_out_ready),
        .grant                    (grant),
        .busy                     (busy),
        .drop_count               (drop_count),
        .pkt_count                (pkt_count)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus state: one pending beat per requester plus beats still to come.
    beat_t             cur [NUM_IN];
    int                rem [NUM_IN];
    logic [NUM_IN-1:0] pend;
    logic [NUM_IN-1:0] gen_mask;
    logic [NUM_IN-1:0] hold_mask;
    logic [NUM_IN-1:0] orph_mask;
    int                gen_mode;
    int                fix_len;
    int                gap_pct;
    int                rdy_pct;

    // Scoreboard: beats each requester has issued and not yet seen on the output.
    beat_t             exp_q [NUM_IN][$];
    bit                mon_en;
    int                m_last;
    int                m_drop;
    logic [15:0]       m_pkt;
    logic              m_prev_busy;
    logic [NUM_IN-1:0] m_prev_offer;

    logic              s_valid;
    logic [2:0]        s_grant;
    logic              s_busy;
    logic [NUM_IN-1:0] s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_IN-1:0] offer);
        for (int k = 1; k <= NUM_IN; k++) begin
            if (offer[(last + k) % NUM_IN]) return (last + k) % NUM_IN;
        end
        return -1;
    endfunction

    task automatic issue(input int i, input bit sop, input bit eop);
        beat_t b;
        b.d   = $urandom;
        b.sop = sop;
        b.eop = eop;
        b.e   = EMPTY_W'($urandom);
        cur[i]  = b;
        pend[i] = 1'b1;
        exp_q[i].push_back(b);
    endtask

    task automatic start_pkt(input int i, input int len);
        rem[i] = len - 1;
        issue(i, 1'b1, len == 1);
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_IN; i++) begin
            if (orph_mask[i]) begin
                in_valid[i]                       = 1'b1;
                in_startofpacket[i]               = 1'b0;
                in_endofpacket[i]                 = 1'($urandom);
                in_data[i*DATA_W +: DATA_W]       = $urandom;
                in_empty[i*EMPTY_W +: EMPTY_W]    = EMPTY_W'($urandom);
            end else begin
                in_valid[i]                       = pend[i] && !hold_mask[i] && (int'($urandom_range(99)) >= gap_pct);
                in_startofpacket[i]               = cur[i].sop;
                in_endofpacket[i]                 = cur[i].eop;
                in_data[i*DATA_W +: DATA_W]       = cur[i].d;
                in_empty[i*EMPTY_W +: EMPTY_W]    = cur[i].e;
            end
        end
        stream_out_ready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    // One clock: snapshot outputs at the falling edge, then advance stimulus after the rising edge.
    task automatic cycle();
        logic [NUM_IN-1:0] acc;
        @(negedge clk_clk);
        s_valid = stream_out_valid;
        s_grant = grant;
        s_busy  = busy;
        s_ready = in_ready;
        s_data  = stream_out_data;
        s_sop   = stream_out_startofpacket;
        acc     = in_valid & in_ready;
        @(posedge clk_clk);
        #1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc[i] && pend[i] && !orph_mask[i]) begin
                pend[i] = 1'b0;
                if (rem[i] > 0) begin
                    rem[i] = rem[i] - 1;
                    issue(i, 1'b0, rem[i] == 0);
                end
            end
            if (!pend[i] && rem[i] == 0 && gen_mask[i]) begin
                if (gen_mode == 2) start_pkt(i, fix_len);
                else if (gen_mode == 1 && $urandom_range(99) < 30) start_pkt(i, int'($urandom_range(4, 1)));
            end
        end
        apply();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rst_valid"}, stream_out_valid, 0);
        chk({tag, "_rst_ready"}, in_ready, 0);
        chk({tag, "_rst_busy"},  busy, 0);
        chk({tag, "_rst_grant"}, grant, 0);
        chk({tag, "_rst_drop"},  drop_count, 0);
        chk({tag, "_rst_pkt"},   pkt_count, 0);
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < NUM_IN; i++) chk($sformatf("%s_q%0d_left", tag, i), exp_q[i].size(), 0);
    endtask

    task automatic do_reset(input int hold, input bit imm);
        mon_en        = 1'b0;
        reset_reset_n = 1'b0;
        #1;
        if (imm) check_reset_outputs("imm");
        pend      = '0;
        orph_mask = '0;
        hold_mask = '0;
        gen_mask  = '0;
        gen_mode  = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            rem[i] = 0;
            exp_q[i].delete();
        end
        apply();
        repeat (hold) @(posedge clk_clk);
        #1;
        if (!imm) check_reset_outputs("held");
        m_drop        = 0;
        m_pkt         = '0;
        m_last        = NUM_IN - 1;
        m_prev_busy   = 1'b0;
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: checks every cycle against the scoreboard and the arbitration rules.
    always @(negedge clk_clk) begin
        int    g;
        int    eg;
        bit    avail;
        beat_t eb;
        if (mon_en) begin
            if (busy && !m_prev_busy) begin
                eg = rr_pick(m_last, m_prev_offer);
                chk("grant_rr", 64'(grant), 64'(eg));
                m_last = eg;
            end else if (busy) begin
                chk("grant_hold", 64'(grant), 64'(m_last));
            end
            if (busy) begin
                chk("ready_owner", in_ready, NUM_IN'(stream_out_ready) << grant);
                chk("valid_owner", stream_out_valid, in_valid[grant]);
            end else begin
                chk("valid_idle", stream_out_valid, 0);
                chk("ready_orphan", in_ready, in_valid & ~in_startofpacket);
            end
            chk("drop_count", drop_count, 64'(m_drop));
            chk("pkt_count", pkt_count, m_pkt);
            if (stream_out_valid && stream_out_ready) begin
                g     = int'(grant);
                avail = 1'b0;
                if (g < NUM_IN) avail = (exp_q[g].size() > 0);
                chk("beat_avail", avail, 1);
                if (avail) begin
                    eb = exp_q[g].pop_front();
                    chk("beat", {stream_out_data, stream_out_startofpacket, stream_out_endofpacket, stream_out_empty}, eb);
                    if (eb.eop) m_pkt = m_pkt + 16'd1;
                end
            end
            if (!busy) begin
                m_drop = m_drop + $countones(in_valid & ~in_startofpacket);
                if (m_drop > 255) m_drop = 255;
            end
            m_prev_busy = busy;
        end
        m_prev_offer = in_valid & in_startofpacket;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    pk0;
        int    k;
        int    orph_rdy;
        beat_t sb;
        reset_reset_n    = 1'b1;
        in_valid         = '0;
        in_data          = '0;
        in_startofpacket = '0;
        in_endofpacket   = '0;
        in_empty         = '0;
        stream_out_ready = 1'b0;
        mon_en           = 1'b0;
        pend = '0; gen_mask = '0; hold_mask = '0; orph_mask = '0;
        gen_mode = 0; fix_len = 1; gap_pct = 0; rdy_pct = 100;
        for (int i = 0; i < NUM_IN; i++) begin
            rem[i] = 0;
            cur[i] = '0;
        end
        #3;
        do_reset(3, 1'b0);

        // Two simultaneous 3-beat packets: req0 wins, one bubble, then req2.
        start_pkt(0, 3);
        start_pkt(2, 3);
        apply();
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk($sformatf("two_pkt_valid_c%0d", c), s_valid, (c == 0 || c == 4) ? 0 : 1);
            if (c != 0 && c != 4) chk($sformatf("two_pkt_grant_c%0d", c), s_grant, (c < 4) ? 0 : 2);
        end
        chk("two_pkt_count", pkt_count, 2);

        // All requesters offer single-beat packets back to back.
        pk0      = int'(pkt_count);
        gen_mode = 2;
        fix_len  = 1;
        gen_mask = '1;
        for (int i = 0; i < NUM_IN; i++) if (!pend[i]) start_pkt(i, 1);
        apply();
        k = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            chk($sformatf("rr1_valid_c%0d", c), s_valid, (c % 2 == 1) ? 1 : 0);
            if (c % 2 == 1) begin
                chk($sformatf("rr1_grant_c%0d", c), s_grant, (3 + k) % NUM_IN);
                k++;
            end
        end
        chk("rr1_pkt_rate", int'(pkt_count) - pk0, 8);
        gen_mask = '0;
        gen_mode = 0;
        run(20);
        check_drained("rr1");

        // Owner 1 stalls mid-packet while requester 3 waits.
        start_pkt(1, 4);
        apply();
        run(2);
        chk("gap_first_beat_grant", s_grant, 1);
        hold_mask[1] = 1'b1;
        start_pkt(3, 2);
        apply();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk($sformatf("gap_busy_c%0d", c), s_busy, 1);
            chk($sformatf("gap_grant_c%0d", c), s_grant, 1);
            chk($sformatf("gap_valid_c%0d", c), s_valid, 0);
            chk($sformatf("gap_ready3_c%0d", c), s_ready[3], 0);
        end
        hold_mask = '0;
        apply();
        run(15);
        check_drained("gap");

        // Downstream backpressure for 5 cycles while locked.
        start_pkt(0, 4);
        apply();
        cycle();
        rdy_pct = 0;
        apply();
        sb = exp_q[0][0];
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk($sformatf("stall_valid_c%0d", c), s_valid, 1);
            chk($sformatf("stall_data_c%0d", c), s_data, sb.d);
            chk($sformatf("stall_sop_c%0d", c), s_sop, 1);
            chk($sformatf("stall_ready_c%0d", c), s_ready[0], 0);
        end
        rdy_pct = 100;
        apply();
        run(10);
        check_drained("stall");

        // 300 orphan beats on requester 2, then a normal packet from it.
        orph_mask[2] = 1'b1;
        apply();
        orph_rdy = 0;
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (s_ready[2]) orph_rdy++;
        end
        chk("orphan_ready_cycles", orph_rdy, 300);
        chk("orphan_drop_sat", drop_count, 8'hFF);
        orph_mask = '0;
        start_pkt(2, 2);
        apply();
        run(2);
        chk("orphan_then_grant", s_grant, 2);
        run(8);
        check_drained("orphan");

        // Randomised traffic with gaps and backpressure.
        gen_mode = 1;
        gen_mask = '1;
        gap_pct  = 20;
        rdy_pct  = 70;
        run(1500);
        gen_mask = '0;
        gen_mode = 0;
        gap_pct  = 0;
        rdy_pct  = 100;
        apply();
        run(60);
        check_drained("random");

        // Reset in beat 2 of a 4-beat packet from requester 2.
        start_pkt(2, 4);
        apply();
        run(2);
        do_reset(3, 1'b1);
        start_pkt(1, 2);
        start_pkt(3, 2);
        apply();
        cycle();
        chk("post_rst_idle", s_busy, 0);
        cycle();
        chk("post_rst_busy", s_busy, 1);
        chk("post_rst_grant", s_grant, 1);
        run(15);
        check_drained("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/poets_stream_arbiter.md
POETS_STREAM_ARBITER -- requirements
Module: poets_stream_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of requester streams, legal range 2..8.
REQ-002 Parameter DATA_W, default 32, beat data width.
REQ-003 Parameter EMPTY_W, default 2, empty-field width.
REQ-004 clk_clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  NUM_IN  per-requester beat valid.
REQ-007 in_data  in  NUM_IN*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 in_startofpacket  in  NUM_IN  per-requester start-of-packet flag.
REQ-009 in_endofpacket  in  NUM_IN  per-requester end-of-packet flag.
REQ-010 in_empty  in  NUM_IN*EMPTY_W  per-requester empty field, packed like in_data.
REQ-011 in_ready  out  NUM_IN  per-requester ready.
REQ-012 stream_out_valid / stream_out_data / stream_out_startofpacket / stream_out_endofpacket / stream_out_empty  out  1/DATA_W/1/1/EMPTY_W  merged stream toward the node's stream_in.
REQ-013 stream_out_ready  in  1  downstream ready.
REQ-014 grant  out  3  index of the current owner; valid only while busy=1.
REQ-015 busy  out  1  high while a packet is locked to an owner.
REQ-016 drop_count  out  8  saturating count of discarded orphan beats.
REQ-017 pkt_count  out  16  count of completed packets, wraps 0xFFFF->0.

Function
REQ-018 The arbiter SHALL run a two-state FSM: IDLE and LOCKED.
REQ-019 Eligibility in IDLE: a requester is eligible when in_valid[i]=1 and in_startofpacket[i]=1.
REQ-020 Selection in IDLE: round-robin search starting at (last_grant+1) mod NUM_IN; the first eligible index is chosen.
REQ-021 The chosen index SHALL be registered into grant, last_grant SHALL be updated to it, and the FSM SHALL move to LOCKED on the next edge.
REQ-022 No output beat is transferred in IDLE: stream_out_valid=0 and the ready of the chosen requester stays 0.
REQ-023 Latency: the first beat is presented on stream_out exactly 1 cycle after the eligible SOP is first seen.
REQ-024 In LOCKED, all stream_out data/sop/eop/empty fields and stream_out_valid SHALL combinationally equal those of requester grant.
REQ-025 In LOCKED, in_ready[grant]=stream_out_ready, and every other in_ready bit is 0.
REQ-026 A beat transfers when stream_out_valid and stream_out_ready are both 1.
REQ-027 A transfer with endofpacket=1 in LOCKED SHALL return the FSM to IDLE and increment pkt_count.
REQ-028 Back-to-back packets therefore incur exactly one idle bubble cycle.
REQ-029 Ownership: while LOCKED, the owner keeps the output until its EOP transfers, regardless of other requests and of gaps in in_valid[grant].
REQ-030 Single-beat packet (sop=1 and eop=1): occupies one LOCKED cycle, then IDLE.
REQ-031 SOP seen while LOCKED: an owner beat with startofpacket=1 after the first beat is passed through unchanged; no packet restart occurs.
REQ-032 Orphan beats in IDLE: a requester with in_valid=1 and in_startofpacket=0 SHALL get in_ready=1 for that cycle; the beat is discarded and drop_count increments, once per beat, saturating at 0xFF.
REQ-033 Multiple orphans in one cycle: all are discarded, and drop_count adds the number of orphans, saturating at 0xFF.
REQ-034 Orphan beats are never discarded while LOCKED.
REQ-035 No eligible requester in IDLE: the FSM stays in IDLE and grant is held.
REQ-036 After reset, last_grant=NUM_IN-1, so requester 0 has first priority.

Reset
REQ-037 Asynchronous assertion SHALL force IDLE, with grant=0, last_grant=NUM_IN-1, busy=0, drop_count=0, pkt_count=0.
REQ-038 During reset, stream_out_valid=0 and in_ready=0.
REQ-039 Reset asserted mid-packet abandons the packet; the output is not re-presented after deassertion.
REQ-040 Deassertion SHALL be synchronised internally with a 2-flop synchroniser; the first arbitration occurs no earlier than the 2nd edge after deassertion.

Verification
REQ-041 Requesters 0 and 2 each present a 3-beat packet simultaneously, with stream_out_ready=1 -> output carries req0 beats in cycles 1-3, idle in cycle 4, req2 beats in cycles 5-7; pkt_count=2.
REQ-042 All 4 requesters continuously offer 1-beat packets -> grant sequence is 0,1,2,3,0,..., with one packet every 2 cycles.
REQ-043 Owner 1 drops in_valid for 3 cycles mid-packet while requester 3 requests -> output is idle, grant stays 1, and in_ready[3]=0 throughout.
REQ-044 stream_out_ready=0 for 5 cycles while LOCKED -> output fields stable, in_ready[grant]=0, no beats lost.
REQ-045 300 orphan beats on requester 2 while idle -> drop_count=0xFF and in_ready[2]=1 each of those cycles; a subsequent SOP on requester 2 is granted normally.
REQ-046 reset_reset_n pulsed low in beat 2 of a 4-beat packet -> all outputs are at reset values immediately; after release, a fresh SOP on requester 1 is granted first among equal requests from 1 and 3, because round-robin starts at 0.
